// File: rtl/wb_grf_if.sv
// rtl/wb_grf_if.sv - W-stage inputs, register read ports and write-back triple
//
// Bundles the signals between the W-stage pipeline, the D-stage read ports
// and the forwarding network.
//   instr_W, PC_W, PC8_W, D_W, C_W : W-stage instruction, PC, PC+8, load word, ALU result
//   rs_addr, rt_addr               : D-stage read port addresses
//   rs_data, rt_data               : D-stage read port data
//   we_out, waddr_out, wdata_out   : write-back triple exported for forwarding
// master drives the pipeline side, slave is the register file.
interface wb_grf_if;
  logic [31:0] instr_W;
  logic [31:0] PC_W;
  logic [31:0] PC8_W;
  logic [31:0] D_W;
  logic [31:0] C_W;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        we_out;
  logic [4:0]  waddr_out;
  logic [31:0] wdata_out;

  modport master (
    output instr_W, PC_W, PC8_W, D_W, C_W, rs_addr, rt_addr,
    input  rs_data, rt_data, we_out, waddr_out, wdata_out
  );

  modport slave (
    input  instr_W, PC_W, PC8_W, D_W, C_W, rs_addr, rt_addr,
    output rs_data, rt_data, we_out, waddr_out, wdata_out
  );
endinterface

// File: rtl/wb_grf.sv
// rtl/wb_grf.sv - MIPS write-back stage and 32x32 general register file
//
// Decodes the W-stage instruction into a destination register and write data
// (ALU result, link address or extended load data), writes it into $1..$31 on
// the rising clock edge and serves two combinational read ports.
//   clk   : system clock, writes on rising edge
//   reset : asynchronous active-high, clears every register
//   bus   : wb_grf_if.slave (W-stage inputs, read ports, write-back triple)
// BYPASS_EN=1 lets a read port see the write data of the same cycle.
module wb_grf #(
  parameter bit BYPASS_EN = 1'b1
) (
  input logic     clk,
  input logic     reset,
  wb_grf_if.slave bus
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;

  assign op    = bus.instr_W[31:26];
  assign funct = bus.instr_W[5:0];
  assign rt    = bus.instr_W[20:16];
  assign rd    = bus.instr_W[15:11];

  // PC_W is kept for trace only; rs and shamt fields play no part here.
  logic unused_trace;
  assign unused_trace = ^{bus.PC_W, bus.instr_W[25:21], bus.instr_W[10:6]};

  // Load lane selection from the low address bits.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = bus.D_W[7:0];
    case (bus.C_W[1:0])
      2'd0:    ld_byte = bus.D_W[7:0];
      2'd1:    ld_byte = bus.D_W[15:8];
      2'd2:    ld_byte = bus.D_W[23:16];
      default: ld_byte = bus.D_W[31:24];
    endcase
    ld_half = bus.C_W[1] ? bus.D_W[31:16] : bus.D_W[15:0];
  end

  logic        dec_wr;
  logic [4:0]  dec_dest;
  logic [31:0] dec_data;

  always_comb begin
    dec_wr   = 1'b0;
    dec_dest = 5'd0;
    dec_data = 32'd0;
    case (op)
      6'h00: begin
        case (funct)
          6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03: begin
            dec_wr   = 1'b1;
            dec_dest = rd;
            dec_data = bus.C_W;
          end
          6'h09: begin
            dec_wr   = 1'b1;
            dec_dest = rd;
            dec_data = bus.PC8_W;
          end
          default: ;
        endcase
      end
      6'h09, 6'h0c, 6'h0d, 6'h0f, 6'h0a: begin
        dec_wr   = 1'b1;
        dec_dest = rt;
        dec_data = bus.C_W;
      end
      6'h03: begin
        dec_wr   = 1'b1;
        dec_dest = 5'd31;
        dec_data = bus.PC8_W;
      end
      6'h23: begin
        dec_wr   = 1'b1;
        dec_dest = rt;
        dec_data = bus.D_W;
      end
      6'h20, 6'h24: begin
        dec_wr   = 1'b1;
        dec_dest = rt;
        // op[2] distinguishes the unsigned variant (lbu)
        dec_data = {{24{ld_byte[7] & ~op[2]}}, ld_byte};
      end
      6'h21, 6'h25: begin
        dec_wr   = 1'b1;
        dec_dest = rt;
        dec_data = {{16{ld_half[15] & ~op[2]}}, ld_half};
      end
      default: ;
    endcase
  end

  // Writes to $0 are suppressed here so the array never needs a $0 entry.
  assign bus.we_out    = dec_wr && (dec_dest != 5'd0) && !reset;
  assign bus.waddr_out = bus.we_out ? dec_dest : 5'd0;
  assign bus.wdata_out = bus.we_out ? dec_data : 32'd0;

  logic [31:0] regs [1:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (bus.we_out) begin
      regs[bus.waddr_out] <= bus.wdata_out;
    end
  end

  always_comb begin
    bus.rs_data = 32'd0;
    if (bus.rs_addr != 5'd0) begin
      if (BYPASS_EN && bus.we_out && (bus.waddr_out == bus.rs_addr)) begin
        bus.rs_data = bus.wdata_out;
      end else begin
        bus.rs_data = regs[bus.rs_addr];
      end
    end
  end

  always_comb begin
    bus.rt_data = 32'd0;
    if (bus.rt_addr != 5'd0) begin
      if (BYPASS_EN && bus.we_out && (bus.waddr_out == bus.rt_addr)) begin
        bus.rt_data = bus.wdata_out;
      end else begin
        bus.rt_data = regs[bus.rt_addr];
      end
    end
  end

endmodule

// File: tb/tb_wb_grf.sv
// tb/tb_wb_grf.sv - randomized bench for wb_grf with bypass on and off
`timescale 1ns/10ps
module tb_wb_grf;

  logic clk;
  logic reset;
  logic chk_en;
  int   total;
  int   bad;

  wb_grf_if bus_b ();
  wb_grf_if bus_n ();

  wb_grf #(.BYPASS_EN(1'b1)) u_byp (.clk(clk), .reset(reset), .bus(bus_b));
  wb_grf #(.BYPASS_EN(1'b0)) u_nob (.clk(clk), .reset(reset), .bus(bus_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model [32];

  logic [5:0] r_functs [12] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b,
                                6'h00, 6'h02, 6'h03, 6'h09, 6'h08, 6'h3f};
  logic [5:0] i_ops [16] = '{6'h09, 6'h0c, 6'h0d, 6'h0f, 6'h0a, 6'h03, 6'h23, 6'h20,
                             6'h24, 6'h21, 6'h25, 6'h2b, 6'h04, 6'h02, 6'h3f, 6'h28};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // What the W stage must write, from the instruction set rules.
  task automatic model_wb(input logic [31:0] ins, input logic [31:0] pc8,
                          input logic [31:0] d, input logic [31:0] c, input logic rst,
                          output logic we, output logic [4:0] a, output logic [31:0] v);
    logic [5:0]  o;
    logic [5:0]  f;
    logic        w;
    logic [4:0]  dst;
    logic [31:0] val;
    int unsigned sh;
    o = ins[31:26];
    f = ins[5:0];
    w = 1'b0;
    dst = 5'd0;
    val = 32'd0;
    if (o == 6'h00 && f inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03}) begin
      w = 1'b1; dst = ins[15:11]; val = c;
    end else if (o == 6'h00 && f == 6'h09) begin
      w = 1'b1; dst = ins[15:11]; val = pc8;
    end else if (o inside {6'h09, 6'h0c, 6'h0d, 6'h0f, 6'h0a}) begin
      w = 1'b1; dst = ins[20:16]; val = c;
    end else if (o == 6'h03) begin
      w = 1'b1; dst = 5'd31; val = pc8;
    end else if (o == 6'h23) begin
      w = 1'b1; dst = ins[20:16]; val = d;
    end else if (o == 6'h20 || o == 6'h24) begin
      sh = 8 * int'(c[1:0]);
      val = (d >> sh) & 32'hFF;
      if (o == 6'h20 && val >= 32'h80) val = val + 32'hFFFFFF00;
      w = 1'b1; dst = ins[20:16];
    end else if (o == 6'h21 || o == 6'h25) begin
      sh = c[1] ? 16 : 0;
      val = (d >> sh) & 32'hFFFF;
      if (o == 6'h21 && val >= 32'h8000) val = val + 32'hFFFF0000;
      w = 1'b1; dst = ins[20:16];
    end
    we = w && dst != 5'd0 && !rst;
    a  = we ? dst : 5'd0;
    v  = we ? val : 32'd0;
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] addr, input bit byp,
                                           input logic we, input logic [4:0] a,
                                           input logic [31:0] v);
    if (addr == 5'd0) return 32'd0;
    if (byp && we && a == addr) return v;
    return model[addr];
  endfunction

  // Compare process: every falling edge, both DUTs against the model.
  always @(negedge clk) begin
    logic        we;
    logic [4:0]  a;
    logic [31:0] v;
    if (chk_en) begin
      model_wb(bus_b.instr_W, bus_b.PC8_W, bus_b.D_W, bus_b.C_W, reset, we, a, v);
      check("byp_we", {31'd0, bus_b.we_out}, {31'd0, we});
      check("byp_waddr", {27'd0, bus_b.waddr_out}, {27'd0, a});
      check("byp_wdata", bus_b.wdata_out, v);
      check("byp_rs", bus_b.rs_data, model_rd(bus_b.rs_addr, 1'b1, we, a, v));
      check("byp_rt", bus_b.rt_data, model_rd(bus_b.rt_addr, 1'b1, we, a, v));
      check("nob_we", {31'd0, bus_n.we_out}, {31'd0, we});
      check("nob_waddr", {27'd0, bus_n.waddr_out}, {27'd0, a});
      check("nob_wdata", bus_n.wdata_out, v);
      check("nob_rs", bus_n.rs_data, model_rd(bus_n.rs_addr, 1'b0, we, a, v));
      check("nob_rt", bus_n.rt_data, model_rd(bus_n.rt_addr, 1'b0, we, a, v));
    end
  end

  // Model array update on the rising edge; reset blocks the write.
  always @(posedge clk) begin
    logic        we;
    logic [4:0]  a;
    logic [31:0] v;
    if (!reset) begin
      model_wb(bus_b.instr_W, bus_b.PC8_W, bus_b.D_W, bus_b.C_W, 1'b0, we, a, v);
      if (we) model[a] = v;
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic set_addr(input logic [4:0] rs, input logic [4:0] rt);
    bus_b.rs_addr = rs; bus_n.rs_addr = rs;
    bus_b.rt_addr = rt; bus_n.rt_addr = rt;
  endtask

  task automatic apply(input logic [31:0] ins, input logic [31:0] pc8, input logic [31:0] d,
                       input logic [31:0] c, input logic [4:0] rs, input logic [4:0] rt);
    bus_b.instr_W = ins; bus_n.instr_W = ins;
    bus_b.PC_W = pc8 - 32'd8; bus_n.PC_W = pc8 - 32'd8;
    bus_b.PC8_W = pc8; bus_n.PC8_W = pc8;
    bus_b.D_W = d; bus_n.D_W = d;
    bus_b.C_W = c; bus_n.C_W = c;
    set_addr(rs, rt);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 2) == 0)
      return {6'h00, r[25:6], r_functs[$urandom_range(0, 11)]};
    return {i_ops[$urandom_range(0, 15)], r[25:0]};
  endfunction

  initial begin
    total = 0;
    bad = 0;
    chk_en = 1'b0;
    clear_model();
    reset = 1'b1;
    apply(32'h0, 32'h8, 32'h0, 32'h0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    apply(32'h0, 32'h8, 32'h0, 32'h0, 5'd1, 5'd31);
    check("rst_we", {31'd0, bus_b.we_out}, 32'd0);
    check("rst_rs", bus_b.rs_data, 32'd0);
    check("rst_rt", bus_b.rt_data, 32'd0);
    reset = 1'b0;

    // lui $1 with same-cycle bypass
    apply(32'h3C01_1234, 32'h108, 32'h0, 32'h1234_0000, 5'd1, 5'd0);
    check("lui_we", {31'd0, bus_b.we_out}, 32'd1);
    check("lui_waddr", {27'd0, bus_b.waddr_out}, 32'd1);
    check("lui_wdata", bus_b.wdata_out, 32'h1234_0000);
    check("lui_byp_rs", bus_b.rs_data, 32'h1234_0000);
    check("lui_nob_rs", bus_n.rs_data, 32'h0);
    tick();
    apply(32'h0, 32'h10c, 32'h0, 32'h0, 5'd1, 5'd1);
    check("lui_after", bus_b.rs_data, 32'h1234_0000);
    check("lui_after_nob", bus_n.rt_data, 32'h1234_0000);
    tick();

    // byte/half loads into $2
    apply(32'h8002_0000, 32'h0, 32'h80FF_7F01, 32'h1, 5'd2, 5'd0);
    check("lb1", bus_b.wdata_out, 32'h0000_007F);
    check("lb1_byp", bus_b.rs_data, 32'h0000_007F);
    tick();
    apply(32'h8002_0000, 32'h0, 32'h80FF_7F01, 32'h2, 5'd2, 5'd0);
    check("lb2", bus_b.wdata_out, 32'hFFFF_FFFF);
    tick();
    apply(32'h8002_0000, 32'h0, 32'h80FF_7F01, 32'h3, 5'd2, 5'd0);
    check("lb3", bus_b.wdata_out, 32'hFFFF_FF80);
    tick();
    apply(32'h9002_0000, 32'h0, 32'h80FF_7F01, 32'h3, 5'd2, 5'd0);
    check("lbu3", bus_b.wdata_out, 32'h0000_0080);
    tick();
    apply(32'h8402_0000, 32'h0, 32'h80FF_7F01, 32'h2, 5'd2, 5'd0);
    check("lh2", bus_b.wdata_out, 32'hFFFF_80FF);
    tick();
    apply(32'h9402_0000, 32'h0, 32'h80FF_7F01, 32'h2, 5'd2, 5'd0);
    check("lhu2", bus_b.wdata_out, 32'h0000_80FF);
    tick();

    // jal / jalr link values
    apply(32'h0C00_0000, 32'h0000_3008, 32'h0, 32'h0, 5'd0, 5'd0);
    check("jal_waddr", {27'd0, bus_b.waddr_out}, 32'd31);
    check("jal_wdata", bus_b.wdata_out, 32'h0000_3008);
    tick();
    apply(32'h0000_2809, 32'h0000_4010, 32'h0, 32'h0, 5'd31, 5'd0);
    check("jal_reg", bus_b.rs_data, 32'h0000_3008);
    check("jalr_waddr", {27'd0, bus_b.waddr_out}, 32'd5);
    tick();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd2);
    check("jalr_reg", bus_n.rs_data, 32'h0000_4010);
    check("lhu_reg", bus_n.rt_data, 32'h0000_80FF);
    tick();

    // ori $3 with bypass off vs on
    apply(32'h3403_0007, 32'h0, 32'h0, 32'h7, 5'd3, 5'd3);
    check("ori_nob_rs", bus_n.rs_data, 32'h0);
    check("ori_nob_rt", bus_n.rt_data, 32'h0);
    check("ori_byp_rt", bus_b.rt_data, 32'h7);
    tick();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3);
    check("ori_after_nob", bus_n.rs_data, 32'h7);
    tick();

    // write to $0 and store: no write
    apply(32'h0000_0021, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    check("addu0_we", {31'd0, bus_b.we_out}, 32'd0);
    check("addu0_wdata", bus_b.wdata_out, 32'd0);
    check("addu0_rs", bus_b.rs_data, 32'd0);
    tick();
    apply(32'hAC03_0000, 32'h0, 32'h55, 32'h99, 5'd3, 5'd0);
    check("sw_we", {31'd0, bus_b.we_out}, 32'd0);
    tick();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0);
    check("sw_keep", bus_b.rs_data, 32'h7);
    tick();

    // fill with ones, then reset mid-cycle with a write pending
    for (int i = 1; i < 32; i++) begin
      apply({6'h0d, 5'd0, 5'(i), 16'hFFFF}, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'(i), 5'd0);
      tick();
    end
    apply(32'h3C04_ABCD, 32'h0, 32'h0, 32'hABCD_0000, 5'd31, 5'd1);
    check("fill_31", bus_n.rs_data, 32'hFFFF_FFFF);
    reset = 1'b1;
    clear_model();
    #0.1;
    for (int k = 0; k < 16; k++) begin
      set_addr(5'(2 * k), 5'(2 * k + 1));
      #0.2;
      check("rstmid_rs", bus_n.rs_data, 32'd0);
      check("rstmid_rt", bus_b.rt_data, 32'd0);
    end
    check("rstmid_we", {31'd0, bus_b.we_out}, 32'd0);
    tick();
    reset = 1'b0;
    apply(32'h0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd1);
    check("rst_drop4", bus_n.rs_data, 32'd0);
    check("rst_drop1", bus_n.rt_data, 32'd0);
    tick();

    // randomized traffic with occasional reset pulses
    for (int n = 0; n < 800; n++) begin
      logic [31:0] ins;
      logic [4:0]  ra;
      logic [4:0]  rb;
      ins = rand_instr();
      ra = ($urandom_range(0, 1) == 0) ? ins[20:16] : 5'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? ins[15:11] : 5'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 5'd31;
      apply(ins, $urandom, $urandom, $urandom, ra, rb);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        clear_model();
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Write-back stage plus general register file for the 5-stage MIPS core.
- Consumes the W-stage pipeline outputs: instruction, PC, PC+8, memory read word and ALU result.
- Decodes the destination register and its source, applies load byte/half extension, and writes the 32x32 register file.
- Serves the two D-stage read ports with same-cycle write-through, and exports the write-back triple for forwarding.

Parameters:
- BYPASS_EN, 1, 1 = read ports return same-cycle write data when addresses match; 0 = pure array read.

Ports:
- clk  in  1  system clock; all writes on rising edge.
- reset  in  1  asynchronous, active-high reset; clears the whole register file.
- instr_W  in  32  instruction in W stage.
- PC_W  in  32  PC of W-stage instruction (trace only).
- PC8_W  in  32  PC+8 link value.
- D_W  in  32  aligned memory read word.
- C_W  in  32  ALU result / memory address.
- rs_addr  in  5  read port A address.
- rt_addr  in  5  read port B address.
- rs_data  out  32  read port A data.
- rt_data  out  32  read port B data.
- we_out  out  1  write-back enable this cycle.
- waddr_out  out  5  write-back register number.
- wdata_out  out  32  write-back data.

Behaviour:
- Storage: registers $1..$31, 32 bits each. $0 is not stored and always reads 0.
- Reset (async): while reset=1, all registers are 0 immediately, and we_out=0, waddr_out=0, wdata_out=0. Consequently rs_data=rt_data=0. No write occurs on a clock edge while reset=1. Deassertion needs no special sequencing.
- Decode uses op=instr_W[31:26], funct=instr_W[5:0], rt=[20:16], rd=[15:11].
  - R-type (op 0x00), funct in {0x21 addu, 0x23 subu, 0x24 and, 0x25 or, 0x2a slt, 0x2b sltu, 0x00 sll, 0x02 srl, 0x03 sra}: dest=rd, data=C_W.
  - jalr (op 0x00, funct 0x09): dest=rd, data=PC8_W.
  - I-type op in {0x09 addiu, 0x0c andi, 0x0d ori, 0x0f lui, 0x0a slti}: dest=rt, data=C_W.
  - jal (op 0x03): dest=31, data=PC8_W.
  - Loads: dest=rt, data extracted from D_W:
    - lw (0x23): D_W, address bits ignored.
    - lb (0x20) / lbu (0x24): byte selected by C_W[1:0] (0 -> D_W[7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24]); lb sign-extends, lbu zero-extends.
    - lh (0x21) / lhu (0x25): C_W[1]=0 -> D_W[15:0], 1 -> D_W[31:16]; lh sign-extends, lhu zero-extends. C_W[0] ignored.
  - Every other encoding (stores, branches, j, undefined): no write.
- we_out = decoded write AND dest != 0 AND !reset. When we_out=0, waddr_out=0 and wdata_out=0. Outputs are combinational from the W-stage inputs: zero latency.
- Write: on rising clk with we_out=1, reg[waddr_out] <= wdata_out. The value is visible through the array from the next cycle.
- Read (combinational):
  - addr=0 -> 0.
  - Else if BYPASS_EN and we_out and waddr_out==addr -> wdata_out.
  - Else reg[addr].
  - Both ports are independent; both may hit the bypass simultaneously.
- Nop (0x00000000, sll $0) and any write to $0: we_out=0, the array is unchanged, and $0 still reads 0.
- Reset asserted mid-operation (between edges): the array clears at once and any pending write is dropped.

Test Plan:
- Assert reset after filling $1..$31 with 0xFFFFFFFF -> all 32 reads give 0 before the next clk edge; we_out=0.
- instr_W=0x3C01_1234 (lui $1), C_W=0x12340000 -> we_out=1, waddr_out=1, wdata_out=0x12340000. With rs_addr=1 in the same cycle, rs_data=0x12340000 (bypass). After the edge, with a nop in W, rs_data still 0x12340000.
- lb $2 (op 0x20, rt=2), D_W=0x80FF7F01: C_W[1:0]=1 -> 0x0000007F; =2 -> 0xFFFFFFFF; =3 -> 0xFFFFFF80. lbu at =3 -> 0x00000080. lh at C_W=2 -> 0xFFFF80FF; lhu -> 0x000080FF.
- jal with PC8_W=0x00003008 -> register 31 = 0x00003008. jalr rd=5 -> $5 = PC8_W.
- addu with rd=0, C_W=0xDEADBEEF -> we_out=0, $0 reads 0. sw (op 0x2b) -> we_out=0, array unchanged.
- BYPASS_EN=0, ori $3 with C_W=7, rs_addr=rt_addr=3 -> old value in the write cycle, 7 after the edge.
